cplx_alu_seq: RTL and testbench
===============================

Name: cplx_alu_seq

Overview:
- Parametrised, handshaked complex arithmetic unit; generalises the combinational complex add/sub.
- Operations: add, subtract, and complex multiply; multiply time-shares one signed N x N multiplier over 4 cycles.
- Sits between an operand source and a result sink, both using valid/ready handshakes.
- Full-precision outputs; no overflow is possible.

Parameters:
- N, 4, operand width in bits (signed two's complement); N >= 2.
- OW, 2*N+1, result width. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  unit can accept an operand set
- op  in  2  operation: 0=ADD, 1=SUB, 2=MUL, 3=MAC (MAC only with optional feature)
- rin1, iin1  in  N  operand A real/imag, signed
- rin2, iin2  in  N  operand B real/imag, signed
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- rout, iout  out  OW  result real/imag, signed
- busy  out  1  multiply in progress

Behaviour:
- Reset (async, immediate):
  - state=IDLE, cnt=0, out_valid=0, rout=iout=0, busy=0.
  - Accumulator (if present) cleared.
  - Operands latched before reset are discarded; an in-flight multiply is abandoned and produces no output.
- States: IDLE, MUL.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; never depends on in_valid.
- Accept = in_valid && in_ready at a rising edge. On accept, latch op and all four operands.
- ADD/SUB, latency 1:
  - On the accept edge: rout = sext(rin1) ± sext(rin2), iout = sext(iin1) ± sext(iin2); out_valid=1.
  - Each result is computed at N+1 bits, then sign-extended to OW.
- MUL, latency 4:
  - On the accept edge: state→MUL, cnt=0, busy=1, partial registers cleared.
  - Edge with cnt=0: pr += a*c. cnt=1: pr -= b*d. cnt=2: pi += a*d. cnt=3: pi += b*c.
    - a=rin1, b=iin1, c=rin2, d=iin2 (latched values).
    - Each product is N x N signed, 2N bits, sign-extended to OW.
  - On the cnt=3 edge: rout=pr_final, iout=pi_final, out_valid=1, busy=0, state→IDLE.
  - out_valid rises exactly 4 edges after the accept edge.
- Output hold: while out_valid && !out_ready, rout, iout and out_valid are held stable and in_ready=0.
- Result consumption:
  - out_valid && out_ready at an edge consumes the result. out_valid drops unless a new accept happens on the same edge.
  - For ADD/SUB, a same-edge accept makes out_valid stay 1 with the new result: back-to-back throughput of 1 per cycle.
  - For MUL, out_valid drops on the consume edge and the unit enters MUL.
- Simultaneous consume + accept is legal and loses no data.
- Input changes while in MUL are ignored; in_ready=0 throughout MUL.
- op=3 without the feature is treated as ADD.
- Width: OW=2N+1 holds worst case (-2^(N-1))^2 + (-2^(N-1))^2 = 2^(2N-1) without wrap.

Optional Feature:
- Macro CPLX_ALU_MAC_EN.
- Defined: op=3 (MAC) performs the 4-cycle multiply, then adds the product to an internal OW-bit complex accumulator (acc_r, acc_i).
  - Output = updated accumulator; latency 4; accumulator arithmetic wraps modulo 2^OW.
  - Any ADD/SUB/MUL leaves the accumulator untouched; reset clears it.
- Not defined: no accumulator registers are built; op=3 behaves exactly as ADD.

Test Plan:
- ADD, N=4: A=3+2j, B=-1+5j, out_ready=1 → out_valid 1 cycle after accept, rout=2, iout=7.
- SUB back-to-back: (3+2j)-(-1+5j) then (-8-8j)-(7+7j) on consecutive cycles → 4-3j then -15-15j on consecutive cycles, in_ready stays 1.
- MUL: (3+2j)*(1-4j) → busy=1 for 4 cycles, in_ready=0, out_valid 4 edges after accept, rout=11, iout=-10. Corner case (-8-8j)*(-8-8j) → rout=0, iout=128, no wrap in 9 bits.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result → result and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready → consumed, then the next operand is accepted.
- Reset mid-MUL: assert rst at cnt=2 → out_valid=0, rout=iout=0, busy=0 immediately. After release, in_ready=1 and no stale result appears.
- With CPLX_ALU_MAC_EN: MAC (1+1j)*(2+0j) twice → results 2+2j then 4+4j. A MUL in between does not change the accumulator. Without the macro, op=3 with A=1+1j, B=2+0j → 3+1j.

Source files
------------

// File: rtl/cplx_alu_seq.sv
// cplx_alu_seq: valid/ready complex add, subtract and 4-cycle multiply sharing one N x N multiplier.
// Optional macro CPLX_ALU_MAC_EN: op=3 multiplies and accumulates into an internal complex accumulator.
module cplx_alu_seq #(
    parameter int N  = 4,
    parameter int OW = 2*N+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [N-1:0]  rin1,
    input  logic [N-1:0]  iin1,
    input  logic [N-1:0]  rin2,
    input  logic [N-1:0]  iin2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] rout,
    output logic [OW-1:0] iout,
    output logic          busy
);

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    // Add/sub at N+1 bits, then sign-extend to the full result width.
    function automatic logic signed [OW-1:0] addsub(input logic signed [N-1:0] x,
                                                    input logic signed [N-1:0] y,
                                                    input logic            sub);
        logic signed [N:0] r;
        if (sub) r = {x[N-1], x} - {y[N-1], y};
        else     r = {x[N-1], x} + {y[N-1], y};
        return {{(OW-N-1){r[N]}}, r};
    endfunction

    function automatic logic signed [2*N-1:0] sx2(input logic signed [N-1:0] x);
        return {{N{x[N-1]}}, x};
    endfunction

    function automatic logic signed [OW-1:0] widen(input logic signed [2*N-1:0] p);
        return {{(OW-2*N){p[2*N-1]}}, p};
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  ovld_q, ovld_d;
    logic signed [OW-1:0]  rout_q, rout_d, iout_q, iout_d;
    logic signed [OW-1:0]  pr_q, pr_d, pi_q, pi_d;
    logic signed [N-1:0]   a_q, b_q, c_q, d_q;
    logic signed [2*N-1:0] mx, my, prod;
    logic signed [OW-1:0]  prod_w, pi_fin;
    logic                  accept, in_is_mul, in_is_sub;

`ifdef CPLX_ALU_MAC_EN
    logic                  mac_q;
    logic signed [OW-1:0]  acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    assign in_is_mul = op[1];
`else
    assign in_is_mul = (op == 2'd2);
`endif
    assign in_is_sub = (op == 2'd1);
    assign accept    = in_valid && in_ready;

    assign out_valid = ovld_q;
    assign rout      = rout_q;
    assign iout      = iout_q;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (accept && in_is_mul) state_d = S_MUL;
        end else if (cnt_q == 2'd3) begin
            state_d = S_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == S_IDLE) && (!ovld_q || out_ready);
        busy     = (state_q == S_MUL);
    end

    // One product per MUL cycle: a*c, b*d, a*d, b*c.
    always_comb begin
        mx = sx2(a_q);
        my = sx2(c_q);
        case (cnt_q)
            2'd0: begin mx = sx2(a_q); my = sx2(c_q); end
            2'd1: begin mx = sx2(b_q); my = sx2(d_q); end
            2'd2: begin mx = sx2(a_q); my = sx2(d_q); end
            2'd3: begin mx = sx2(b_q); my = sx2(c_q); end
        endcase
        prod   = mx * my;
        prod_w = widen(prod);
        pi_fin = pi_q + prod_w;
    end

    always_comb begin
        cnt_d  = cnt_q;
        pr_d   = pr_q;
        pi_d   = pi_q;
        rout_d = rout_q;
        iout_d = iout_q;
        ovld_d = ovld_q;
`ifdef CPLX_ALU_MAC_EN
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
`endif
        if (ovld_q && out_ready) ovld_d = 1'b0;
        if (accept) begin
            if (in_is_mul) begin
                cnt_d  = 2'd0;
                pr_d   = '0;
                pi_d   = '0;
                ovld_d = 1'b0;
            end else begin
                rout_d = addsub(rin1, rin2, in_is_sub);
                iout_d = addsub(iin1, iin2, in_is_sub);
                ovld_d = 1'b1;
            end
        end else if (state_q == S_MUL) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0: pr_d = pr_q + prod_w;
                2'd1: pr_d = pr_q - prod_w;
                2'd2: pi_d = pi_fin;
                2'd3: begin
                    pi_d   = pi_fin;
                    ovld_d = 1'b1;
`ifdef CPLX_ALU_MAC_EN
                    if (mac_q) begin
                        acc_r_d = acc_r_q + pr_q;
                        acc_i_d = acc_i_q + pi_fin;
                        rout_d  = acc_r_d;
                        iout_d  = acc_i_d;
                    end else begin
                        rout_d = pr_q;
                        iout_d = pi_fin;
                    end
`else
                    rout_d = pr_q;
                    iout_d = pi_fin;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            ovld_q <= 1'b0;
            rout_q <= '0;
            iout_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ovld_q <= ovld_d;
            rout_q <= rout_d;
            iout_q <= iout_d;
        end
    end

    // Operands and partial sums carry no reset: an abandoned multiply never reaches the output.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= rin1;
            b_q <= iin1;
            c_q <= rin2;
            d_q <= iin2;
        end
        pr_q <= pr_d;
        pi_q <= pi_d;
    end

`ifdef CPLX_ALU_MAC_EN
    always_ff @(posedge clk) begin
        if (accept) mac_q <= (op == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r_q <= '0;
            acc_i_q <= '0;
        end else begin
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
        end
    end
`endif

endmodule

// File: tb/tb_cplx_alu_seq.sv
// Self-checking bench for cplx_alu_seq: directed cases plus randomized transactions vs. a complex-math model.
module tb_cplx_alu_seq;

    localparam int N  = 4;
    localparam int OW = 2*N+1;
`ifdef CPLX_ALU_MAC_EN
    localparam bit MAC = 1'b1;
`else
    localparam bit MAC = 1'b0;
`endif

    logic          clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]    op;
    logic [N-1:0]  rin1, iin1, rin2, iin2;
    logic [OW-1:0] rout, iout;

    int n_asrt = 0;
    int n_fail = 0;
    int acc_r  = 0;
    int acc_i  = 0;

    cplx_alu_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rin1(rin1), .iin1(iin1), .rin2(rin2), .iin2(iin2),
        .out_valid(out_valid), .out_ready(out_ready), .rout(rout), .iout(iout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 15)) - 8;
    endfunction

    function automatic int wrap(input int v);
        logic signed [OW-1:0] t;
        t = v[OW-1:0];
        return int'(t);
    endfunction

    task automatic drive(input int opc, input int a, input int b, input int c, input int d);
        op   = opc[1:0];
        rin1 = a[N-1:0];
        iin1 = b[N-1:0];
        rin2 = c[N-1:0];
        iin2 = d[N-1:0];
    endtask

    // Reference: plain complex arithmetic; wait = edges after the accept edge until the result.
    task automatic model(input int opc, input int a, input int b, input int c, input int d,
                         output int er, output int ei, output int wt);
        int pr, pi;
        pr = a*c - b*d;
        pi = a*d + b*c;
        if (opc == 1) begin
            er = a - c; ei = b - d; wt = 0;
        end else if (opc == 2) begin
            er = pr; ei = pi; wt = 4;
        end else if (opc == 3 && MAC) begin
            acc_r = wrap(acc_r + pr);
            acc_i = wrap(acc_i + pi);
            er = acc_r; ei = acc_i; wt = 4;
        end else begin
            er = a + c; ei = b + d; wt = 0;
        end
    endtask

    task automatic xact(input string tag, input int opc, input int a, input int b,
                        input int c, input int d, input int hold);
        int er, ei, wt, w;
        int hr, hi;
        model(opc, a, b, c, d, er, ei, wt);
        w = 0;
        while (!in_ready && w < 10) begin tick(); w++; end
        chk({tag, "_rdy"}, in_ready, 1);
        drive(opc, a, b, c, d);
        in_valid = 1'b1;
        tick();
        // Keep offering junk during a multiply; it must be ignored.
        in_valid = (wt > 0);
        drive(int'($urandom_range(0, 3)), rnd(), rnd(), rnd(), rnd());
        w = 0;
        while (!out_valid && w < 10) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nrdy"}, in_ready, 0);
            tick();
            w++;
        end
        in_valid = 1'b0;
        chk({tag, "_wait"}, w, wt);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_re"}, $signed(rout), er);
        chk({tag, "_im"}, $signed(iout), ei);
        if (hold > 0) begin
            out_ready = 1'b0;
            hr = int'($signed(rout));
            hi = int'($signed(iout));
            repeat (hold) begin
                tick();
                chk({tag, "_hvld"}, out_valid, 1);
                chk({tag, "_hre"}, $signed(rout), hr);
                chk({tag, "_him"}, $signed(iout), hi);
                chk({tag, "_hrdy"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        tick();
        chk({tag, "_drop"}, out_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_vld", out_valid, 0);
        chk("rst_re", $signed(rout), 0);
        chk("rst_im", $signed(iout), 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("rst_rdy", in_ready, 1);

        xact("add", 0, 3, 2, -1, 5, 0);
        chk("add_re_const", $signed(rout), 2);
        chk("add_im_const", $signed(iout), 7);

        // Back-to-back SUB, one result per cycle.
        drive(1, 3, 2, -1, 5);
        in_valid = 1'b1;
        tick();
        chk("b2b1_vld", out_valid, 1);
        chk("b2b1_re", $signed(rout), 4);
        chk("b2b1_im", $signed(iout), -3);
        chk("b2b1_rdy", in_ready, 1);
        drive(1, -8, -8, 7, 7);
        tick();
        chk("b2b2_vld", out_valid, 1);
        chk("b2b2_re", $signed(rout), -15);
        chk("b2b2_im", $signed(iout), -15);
        chk("b2b2_rdy", in_ready, 1);
        in_valid = 1'b0;
        tick();
        chk("b2b_drop", out_valid, 0);

        xact("mul", 2, 3, 2, 1, -4, 0);
        chk("mul_re_const", $signed(rout), 11);
        chk("mul_im_const", $signed(iout), -10);
        xact("mul_corner", 2, -8, -8, -8, -8, 0);
        chk("corner_re_const", $signed(rout), 0);
        chk("corner_im_const", $signed(iout), 128);

        // Backpressure, then consume and accept on the same edge.
        out_ready = 1'b0;
        drive(0, 3, 2, -1, 5);
        in_valid = 1'b1;
        tick();
        drive(0, 1, 1, 1, 1);
        repeat (5) begin
            chk("bp_vld", out_valid, 1);
            chk("bp_re", $signed(rout), 2);
            chk("bp_im", $signed(iout), 7);
            chk("bp_rdy", in_ready, 0);
            tick();
        end
        drive(1, 5, 5, 2, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_up", in_ready, 1);
        tick();
        chk("bp_new_vld", out_valid, 1);
        chk("bp_new_re", $signed(rout), 3);
        chk("bp_new_im", $signed(iout), 4);
        in_valid = 1'b0;
        tick();
        chk("bp_drop", out_valid, 0);

        // Reset while the multiply is at cnt=2.
        drive(2, 3, 2, 1, -4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rmul_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rmul_vld", out_valid, 0);
        chk("rmul_re", $signed(rout), 0);
        chk("rmul_im", $signed(iout), 0);
        chk("rmul_busy0", busy, 0);
        #2 rst = 1'b0;
        acc_r = 0;
        acc_i = 0;
        tick();
        chk("rmul_rdy", in_ready, 1);
        repeat (6) begin
            chk("rmul_stale", out_valid, 0);
            tick();
        end

`ifdef CPLX_ALU_MAC_EN
        xact("mac1", 3, 1, 1, 2, 0, 0);
        chk("mac1_re_const", $signed(rout), 2);
        chk("mac1_im_const", $signed(iout), 2);
        xact("mac_mul", 2, 3, 2, 1, -4, 0);
        xact("mac2", 3, 1, 1, 2, 0, 0);
        chk("mac2_re_const", $signed(rout), 4);
        chk("mac2_im_const", $signed(iout), 4);
`else
        xact("op3_add", 3, 1, 1, 2, 0, 0);
        chk("op3_re_const", $signed(rout), 3);
        chk("op3_im_const", $signed(iout), 1);
`endif

        for (int i = 0; i < 60; i++) begin
            int hold;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            xact("rnd", int'($urandom_range(0, 3)), rnd(), rnd(), rnd(), rnd(), hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
